seg_display_arbiter: RTL and testbench

- Owns the shared 4-digit multiplexed 7-segment display and arbitrates it among four service requesters: time set, alarm set, stopwatch and mini-game count.
- Falls back to a default source (running clock time) when no requester is active.
- Performs digit scanning, per-digit blink masking, BCD-to-segment decode and a full-display alarm flash.
- Grant changes only at frame boundaries, with a one-digit blank gap, so no mixed-source frame ever reaches the display.

---
 rtl/seg_display_arbiter_pkg.sv | 39 +++
 rtl/seg_display_arbiter_if.sv | 32 +++
 rtl/seg_display_arbiter_decoder.sv | 32 +++
 rtl/seg_display_arbiter.sv | 141 ++++++++++++++
 tb/tb_seg_display_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_display_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_disp_pkg
// Purpose  : Shared constants and types for the 7-segment display arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package seg_disp_pkg;

    localparam int NUM_REQ = 4;
    localparam int WORD_W  = 16;

    // Active-low segments, ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ALL   = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    localparam int REQ_TSET = 0;
    localparam int REQ_ASET = 1;
    localparam int REQ_SW   = 2;
    localparam int REQ_GAME = 3;

    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

endpackage : seg_disp_pkg
`default_nettype wire

// File: rtl/seg_display_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_arbiter_if
// Purpose  : Requester-side inputs and display-side outputs of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_display_arbiter_if;
    import seg_disp_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*WORD_W-1:0] num_bus;
    logic [NUM_REQ*4-1:0]      blink_mask;
    logic [WORD_W-1:0]         default_num;
    logic                      alarm_flash;
    logic [3:0]                anode;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_REQ-1:0]        grant;
    logic                      frame_done;

    modport master (
        output req, num_bus, blink_mask, default_num, alarm_flash,
        input  anode, seg, dp, grant, frame_done
    );

    modport slave (
        input  req, num_bus, blink_mask, default_num, alarm_flash,
        output anode, seg, dp, grant, frame_done
    );

endinterface : seg_display_arbiter_if
`default_nettype wire

// File: rtl/seg_display_arbiter_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_decoder
// Purpose  : BCD nibble to active-low 7-segment pattern; A-F decode blank.
// Revision : 1.0 - initial release
// ============================================================================
module seg_decoder
    import seg_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule : seg_decoder
`default_nettype wire

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_arbiter
// Purpose  : Frame-synchronous arbitration and scanning of a shared 4-digit
//            display. Define DP_COLON_EN for a blinking colon on digit 2.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 16,
    parameter int BLINK_DIV = 24,
    parameter int N_REQ     = 4
)(
    input  logic                  clk_osc,
    input  logic                  reset,
    seg_display_arbiter_if.slave  bus
);

    localparam int CW = SCAN_DIV + 2;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BLINK_DIV:0] blink_q, blink_d;
    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d, winner;
    logic [3:0]         anode_q, anode_d;
    logic [6:0]         seg_q, seg_d, dec_seg;
    logic               fd_q;
    logic [1:0]         digit;
    logic               dwell_end, frame_end, blink_ph;
    logic [WORD_W-1:0]  src_word;
    logic [3:0]         src_mask;

    assign cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    assign blink_d   = blink_q + {{BLINK_DIV{1'b0}}, 1'b1};
    assign digit     = cnt_q[CW-1 -: 2];
    assign dwell_end = &cnt_q[SCAN_DIV-1:0];
    assign frame_end = &cnt_q;
    assign blink_ph  = blink_q[BLINK_DIV];

    always_comb begin
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                winner    = '0;
                winner[k] = 1'b1;
            end
        end
    end

    // The default source carries no blink mask, so it never blinks.
    always_comb begin
        src_word = bus.default_num;
        src_mask = 4'b0000;
        if (grant_q[REQ_TSET]) begin
            src_word = bus.num_bus[REQ_TSET*WORD_W +: WORD_W];
            src_mask = bus.blink_mask[REQ_TSET*4 +: 4];
        end else if (grant_q[REQ_ASET]) begin
            src_word = bus.num_bus[REQ_ASET*WORD_W +: WORD_W];
            src_mask = bus.blink_mask[REQ_ASET*4 +: 4];
        end else if (grant_q[REQ_SW]) begin
            src_word = bus.num_bus[REQ_SW*WORD_W +: WORD_W];
            src_mask = bus.blink_mask[REQ_SW*4 +: 4];
        end else if (grant_q[REQ_GAME]) begin
            src_word = bus.num_bus[REQ_GAME*WORD_W +: WORD_W];
            src_mask = bus.blink_mask[REQ_GAME*4 +: 4];
        end
    end

    seg_decoder u_dec (
        .bcd_i (src_word[4*digit +: 4]),
        .seg_o (dec_seg)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        if (frame_end) begin
            grant_d = winner;
            state_d = (winner != grant_q) ? BLANK : SHOW;
        end else if (state_q == BLANK && dwell_end) begin
            state_d = SHOW;
        end
    end

    always_comb begin
        anode_d = ANODE_OFF;
        seg_d   = SEG_BLANK;
        if (state_q == SHOW) begin
            seg_d = bus.alarm_flash ? SEG_ALL : dec_seg;
            if (bus.alarm_flash || !(src_mask[digit] && blink_ph))
                anode_d = ~(4'b0001 << digit);
        end
    end

    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            blink_q <= '0;
            state_q <= SHOW;
            grant_q <= '0;
            anode_q <= ANODE_OFF;
            seg_q   <= SEG_BLANK;
            fd_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            state_q <= state_d;
            grant_q <= grant_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            fd_q    <= &cnt_d;
        end
    end

`ifdef DP_COLON_EN
    logic dp_q, dp_d;

    always_comb begin
        dp_d = 1'b1;
        if (state_q == SHOW && digit == 2'd2 && !blink_ph && !bus.alarm_flash)
            dp_d = 1'b0;
    end

    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) dp_q <= 1'b1;
        else       dp_q <= dp_d;
    end

    assign bus.dp = dp_q;
`else
    assign bus.dp = 1'b1;
`endif

    assign bus.anode      = anode_q;
    assign bus.seg        = seg_q;
    assign bus.grant      = grant_q;
    assign bus.frame_done = fd_q;

endmodule : seg_display_arbiter
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_arbiter
// Purpose  : Self-checking bench with a time-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_arbiter;

    localparam int D    = 4;       // dwell cycles, 2^SCAN_DIV
    localparam int P    = 4 * D;   // frame length
    localparam int HALF = 32;      // blink half period, 2^BLINK_DIV

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    int         mt = 0;          // cycles into the current frame
    int         bt = 0;          // cycles into the current blink period
    logic [3:0] grant_m = 4'b0;
    logic       new_frame_m = 1'b0;
    logic [6:0] seg_tab [16];

    seg_display_arbiter_if bus ();

    seg_display_arbiter #(
        .SCAN_DIV  (2),
        .BLINK_DIV (5),
        .N_REQ     (4)
    ) dut (
        .clk_osc (clk),
        .reset   (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h (frame pos %0d)", tag, obs, exp, mt);
        end
    endtask

    task automatic step();
        int dig;
        logic ph, blank, e_dp, e_fd, found;
        logic [15:0] word;
        logic [3:0]  msk, e_an, win;
        logic [6:0]  e_sg;
        dig   = mt / D;
        ph    = (bt >= HALF);
        blank = new_frame_m && (dig == 0);
        word  = bus.default_num;
        msk   = 4'b0;
        for (int k = 0; k < 4; k++) begin
            if (grant_m == 4'(1 << k)) begin
                word = bus.num_bus[16*k +: 16];
                msk  = bus.blink_mask[4*k +: 4];
            end
        end
        e_an = 4'b1111;
        e_sg = 7'h7F;
        e_dp = 1'b1;
        if (!blank) begin
            e_sg = bus.alarm_flash ? 7'h00 : seg_tab[word[4*dig +: 4]];
            if (bus.alarm_flash || !(msk[dig] && ph)) e_an[dig] = 1'b0;
`ifdef DP_COLON_EN
            if (dig == 2 && !ph && !bus.alarm_flash) e_dp = 1'b0;
`endif
        end
        if (mt == P - 1) begin
            win   = 4'b0;
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (bus.req[k] && !found) begin
                    win   = 4'(1 << k);
                    found = 1'b1;
                end
            end
            new_frame_m = (win != grant_m);
            grant_m     = win;
        end
        mt   = (mt + 1) % P;
        bt   = (bt + 1) % (2 * HALF);
        e_fd = (mt == P - 1);
        @(posedge clk);
        #1;
        check("anode", 16'(bus.anode), 16'(e_an));
        check("seg", 16'(bus.seg), 16'(e_sg));
        check("dp", 16'(bus.dp), 16'(e_dp));
        check("grant", 16'(bus.grant), 16'(grant_m));
        check("frame_done", 16'(bus.frame_done), 16'(e_fd));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_pos(input int pos);
        for (int i = 0; i < P && mt != pos; i++) step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_anode"}, 16'(bus.anode), 16'h000F);
        check({tag, "_seg"}, 16'(bus.seg), 16'h007F);
        check({tag, "_dp"}, 16'(bus.dp), 16'h0001);
        check({tag, "_grant"}, 16'(bus.grant), 16'h0000);
        check({tag, "_fd"}, 16'(bus.frame_done), 16'h0000);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int i = 0; i < 4; i++)
            w[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
        return w;
    endfunction

    initial begin
        int   steps;
        logic reached;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        bus.req         = 4'b0000;
        bus.num_bus     = {rand_word(), rand_word(), rand_word(), rand_word()};
        bus.blink_mask  = 16'($urandom);
        bus.default_num = 16'h1234;
        bus.alarm_flash = 1'b0;

        // Power-on reset and idle default source
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        @(posedge clk);
        #3;
        rst = 1'b0;
        run(40);

        // Request rising mid-frame waits for the frame boundary
        wait_pos(5);
        bus.req = 4'b0110;
        run(40);

        // Blinking time-set digits 0 and 1
        bus.req        = 4'b0001;
        bus.blink_mask = {12'($urandom), 4'b0011};
        run(150);

        // Invalid nibble on stopwatch, then alarm flash
        bus.num_bus[47:32] = 16'h5A59;
        bus.req            = 4'b0100;
        run(40);
        bus.alarm_flash = 1'b1;
        run(40);
        bus.alarm_flash = 1'b0;

        // A request living inside one frame is never granted
        bus.req = 4'b0000;
        run(2 * P);
        wait_pos(1);
        bus.req = 4'b0001;
        run(8);
        bus.req = 4'b0000;
        run(2 * P);

        // Reset asserted during the blank gap
        bus.req = 4'b1000;
        reached = 1'b0;
        for (steps = 0; steps < 4 * P && !reached; steps++) begin
            step();
            reached = new_frame_m && (mt == 1);
        end
        total++;
        assert (reached === 1'b1) else begin
            bad++;
            $error("FAIL blank_reach: observed=%b expected=1", reached);
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #3;
        rst         = 1'b0;
        mt          = 0;
        bt          = 0;
        grant_m     = 4'b0;
        new_frame_m = 1'b0;
        run(3 * P);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0)
                bus.req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            if ($urandom_range(0, 19) == 0)
                bus.num_bus[16*$urandom_range(0, 3) +: 16] = rand_word();
            if ($urandom_range(0, 29) == 0)
                bus.blink_mask = 16'($urandom);
            if ($urandom_range(0, 19) == 0)
                bus.default_num = rand_word();
            if ($urandom_range(0, 59) == 0)
                bus.alarm_flash = ~bus.alarm_flash;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seg_display_arbiter
`default_nettype wire
